// File: rtl/frame_window_ctrl.sv
// ---------------------------------------------------------------------------
// frame_window_ctrl
//
// Frame-level sequencer for the 3x3 window / filter pipeline. It reads one
// W x H grayscale frame from the source buffer in raster order and streams
// it into the window stage as a valid-qualified pixel stream. It follows the
// window's output stream and writes each interior result to its centre
// address in the result buffer. It pulses frame_done once the frame is
// complete.
//
// Optional feature, selected by the macro BORDER_FILL_EN:
//   When defined, a FILL state writes zero to every border pixel after the
//   interior results have drained. The order is row 0, row H-1, column 0 and
//   then column W-1. When not defined, border pixels are never written and
//   res_wr_sel_zero is tied low.
//
// Parameters:
//   W, H    frame width / height in pixels (both >= 3)
//   ADDR_W  frame-buffer address width, 2**ADDR_W >= W*H
//
// Ports:
//   clk, resetn       clock (rising edge), asynchronous active-low reset
//   start             one-cycle frame request, sampled only in IDLE
//   busy              high in every state except IDLE
//   frame_done        one-cycle completion pulse
//   sink_ready        result sink can accept writes; gates new source reads
//   src_rd_en/addr    source frame-buffer read strobe and address
//   src_rd_data       source read data, valid one cycle after src_rd_en
//   win_in_valid/pixel  pixel stream into the window stage
//   win_out_valid     window output valid (1-cycle latency, in order)
//   res_wr_en/addr    result-buffer write strobe and address
//   res_wr_sel_zero   1 = write zero (border fill), 0 = write filter result
// ---------------------------------------------------------------------------
module frame_window_ctrl #(
    parameter int W      = 160,
    parameter int H      = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    input  logic              sink_ready,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_data,
    output logic              win_in_valid,
    output logic [7:0]        win_in_pixel,
    input  logic              win_out_valid,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic              res_wr_sel_zero
);

    // The output count must be able to hold W*H itself, which may equal
    // 2**ADDR_W, so it is one bit wider than an address.
    localparam int CNT_W = ADDR_W + 1;
    localparam int X_W   = $clog2(W);
    localparam int Y_W   = $clog2(H);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);
    localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(W);
    localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(W * H);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(W - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(H - 1);

`ifdef BORDER_FILL_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FILL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        FP_TOP,
        FP_BOT,
        FP_LEFT,
        FP_RIGHT
    } fill_phase_t;

    // First and last address of each border segment.
    localparam logic [ADDR_W-1:0] TOP_END     = ADDR_W'(W - 1);
    localparam logic [ADDR_W-1:0] BOT_START   = ADDR_W'((H - 1) * W);
    localparam logic [ADDR_W-1:0] BOT_END     = ADDR_W'(H * W - 1);
    localparam logic [ADDR_W-1:0] LEFT_START  = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] LEFT_END    = ADDR_W'((H - 2) * W);
    localparam logic [ADDR_W-1:0] RIGHT_START = ADDR_W'(2 * W - 1);
    localparam logic [ADDR_W-1:0] RIGHT_END   = ADDR_W'((H - 1) * W - 1);

    fill_phase_t       fill_phase_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              fill_we;
    logic              fill_last;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] rd_addr_q;

    // Output-side position tracking. row_base_q always equals oy_q*W. It is
    // kept as a running sum so that no multiplier is needed.
    logic [X_W-1:0]    ox_q;
    logic [Y_W-1:0]    oy_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [CNT_W-1:0]  out_cnt_q;

    logic              track_en;
    logic              int_we;
    logic [ADDR_W-1:0] int_addr;

    assign busy         = (state_q != S_IDLE);
    assign src_rd_addr  = rd_addr_q;
    assign win_in_pixel = src_rd_data;

    // Results are tracked only while a frame is in progress. A stray valid
    // seen in IDLE can therefore never move the counters or cause a write.
    assign track_en = busy && win_out_valid;
    assign int_we   = track_en && (ox_q >= X_W'(2)) && (oy_q >= Y_W'(2));
    // The centre of the window that ends at (ox, oy) is (ox-1, oy-1).
    assign int_addr = row_base_q - W_A + ADDR_W'(ox_q) - ADDR_W'(1);

`ifdef BORDER_FILL_EN
    assign fill_last = (fill_phase_q == FP_RIGHT) && (fill_addr_q == RIGHT_END);
`endif

    // -----------------------------------------------------------------------
    // FSM next-state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default value first. A path
        // that leaves one unassigned would infer a latch.
        state_d    = state_q;
        src_rd_en  = 1'b0;
        frame_done = 1'b0;
`ifdef BORDER_FILL_EN
        fill_we    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                // Reads are issued only when the sink can take their results.
                if (sink_ready) begin
                    src_rd_en = 1'b1;
                    if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == TOTAL) begin
`ifdef BORDER_FILL_EN
                    state_d = S_FILL;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef BORDER_FILL_EN
            S_FILL: begin
                if (sink_ready) begin
                    fill_we = 1'b1;
                    if (fill_last) state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, read address and input stream
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments only. Each
        // register then samples values from before the edge, in any order.
        if (!resetn) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            win_in_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Read data returns one cycle after the strobe, so the strobe
            // delayed by one cycle qualifies the pixel.
            win_in_valid <= src_rd_en;
            if (state_q == S_IDLE) begin
                rd_addr_q <= '0;
            end else if (src_rd_en && (rd_addr_q != LAST_ADDR)) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
            out_cnt_q  <= '0;
        end else if (state_q == S_IDLE) begin
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
            out_cnt_q  <= '0;
        end else if (track_en) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            if (ox_q == X_LAST) begin
                ox_q <= '0;
                if (oy_q == Y_LAST) begin
                    oy_q       <= '0;
                    row_base_q <= '0;
                end else begin
                    oy_q       <= oy_q + 1'b1;
                    row_base_q <= row_base_q + W_A;
                end
            end else begin
                ox_q <= ox_q + 1'b1;
            end
        end
    end

`ifdef BORDER_FILL_EN
    // -----------------------------------------------------------------------
    // Border fill address walk: the top row, then the bottom row, then
    // column 0 and finally column W-1 of the inner rows. A stalled cycle
    // keeps the current address.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_phase_q <= FP_TOP;
            fill_addr_q  <= '0;
        end else if (state_q != S_FILL) begin
            fill_phase_q <= FP_TOP;
            fill_addr_q  <= '0;
        end else if (fill_we) begin
            case (fill_phase_q)
                FP_TOP: begin
                    if (fill_addr_q == TOP_END) begin
                        fill_phase_q <= FP_BOT;
                        fill_addr_q  <= BOT_START;
                    end else begin
                        fill_addr_q <= fill_addr_q + 1'b1;
                    end
                end
                FP_BOT: begin
                    if (fill_addr_q == BOT_END) begin
                        fill_phase_q <= FP_LEFT;
                        fill_addr_q  <= LEFT_START;
                    end else begin
                        fill_addr_q <= fill_addr_q + 1'b1;
                    end
                end
                FP_LEFT: begin
                    if (fill_addr_q == LEFT_END) begin
                        fill_phase_q <= FP_RIGHT;
                        fill_addr_q  <= RIGHT_START;
                    end else begin
                        fill_addr_q <= fill_addr_q + W_A;
                    end
                end
                FP_RIGHT: begin
                    if (!fill_last) fill_addr_q <= fill_addr_q + W_A;
                end
                default: fill_phase_q <= FP_TOP;
            endcase
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Result-buffer write port. The address reads 0 whenever no write is
    // taking place.
    // -----------------------------------------------------------------------
    always_comb begin
        res_wr_en       = int_we;
        res_wr_addr     = int_we ? int_addr : '0;
        res_wr_sel_zero = 1'b0;
`ifdef BORDER_FILL_EN
        if (fill_we) begin
            res_wr_en       = 1'b1;
            res_wr_addr     = fill_addr_q;
            res_wr_sel_zero = 1'b1;
        end
`endif
    end

endmodule
